// File: rtl/sparse_pkg.sv
// Shared types and helpers for the sparse serializer/decoder pair.
// SPARSE_DEC_PARITY_EN appends an even-parity bit to every frame.
package sparse_pkg;

  typedef enum logic {
    RX_IDLE  = 1'b0,
    RX_SHIFT = 1'b1
  } rx_state_t;

`ifdef SPARSE_DEC_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  function automatic int addr_w(input int size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

  // Serial frame length on the wire, including the optional parity bit.
  function automatic int frame_len(input int size);
    return PARITY_EN ? size + 1 : size;
  endfunction

endpackage

// File: rtl/sparse_prio_enc.sv
// Combinational lowest-set-bit encoder; index is 0 when no bit is set.
module sparse_prio_enc
  import sparse_pkg::*;
#(
  parameter int SIZE = 8,
  localparam int AW = addr_w(SIZE)
) (
  input  logic [SIZE-1:0] req,
  output logic [AW-1:0]   index,
  output logic            any
);

  always_comb begin
    index = '0;
    for (int i = SIZE - 1; i >= 0; i--) begin
      if (req[i]) index = AW'(i);
    end
  end

  assign any = |req;

endmodule

// File: rtl/sparse_bitstream_decoder.sv
// Serial sparse frame receiver that replays active addresses lowest-first.
// SPARSE_DEC_PARITY_EN adds a trailing even-parity bit and the parity_err port.
module sparse_bitstream_decoder
  import sparse_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int AW   = addr_w(SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          frame_start,
  input  logic          bitstream_in,
  output logic [AW-1:0] addr_out,
  output logic          addr_valid,
  input  logic          addr_ready,
  output logic          done,
  output logic          overflow,
  output logic          busy
`ifdef SPARSE_DEC_PARITY_EN
  ,
  output logic          parity_err
`endif
);

  localparam int FL = frame_len(SIZE);
  localparam int CW = $clog2(FL);
  localparam logic [CW-1:0] LAST_CNT = CW'(FL - 1);

  rx_state_t       rx_state_reg;
  logic [CW-1:0]   bit_cnt_reg;
  logic [FL-2:0]   shift_reg;
  logic [SIZE-1:0] pending_reg;
  logic            done_reg;
  logic            overflow_reg;

  logic [FL-1:0]   frame_word;
  logic [SIZE-1:0] frame_data;
  logic [SIZE-1:0] pending_clr;
  logic [AW-1:0]   lowest;
  logic            any;
  logic            frame_done, parity_ok, frame_ok;
  logic            hs, final_hs, load;

  sparse_prio_enc #(.SIZE(SIZE)) u_enc (
    .req  (pending_reg),
    .index(lowest),
    .any  (any)
  );

  // Bits enter at the top and walk down, so bit 0 lands at index 0 on the
  // last bit; stale bits from an aborted frame are flushed out the bottom.
  assign frame_word = {bitstream_in, shift_reg};
  assign frame_data = frame_word[SIZE-1:0];

`ifdef SPARSE_DEC_PARITY_EN
  assign parity_ok = ~^frame_word;
`else
  assign parity_ok = 1'b1;
`endif

  assign frame_done = enable & (rx_state_reg == RX_SHIFT) & ~frame_start
                    & (bit_cnt_reg == LAST_CNT);
  assign frame_ok   = frame_done & parity_ok;

  assign addr_valid  = any & enable;
  assign hs          = addr_valid & addr_ready;
  assign pending_clr = pending_reg & ~(SIZE'(1) << lowest);
  assign final_hs    = hs & ~|pending_clr;
  assign load        = frame_ok & (~any | final_hs);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state_reg <= RX_IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      pending_reg  <= '0;
      done_reg     <= 1'b0;
      overflow_reg <= 1'b0;
`ifdef SPARSE_DEC_PARITY_EN
      parity_err   <= 1'b0;
`endif
    end else begin
      overflow_reg <= frame_ok & ~load;
`ifdef SPARSE_DEC_PARITY_EN
      parity_err   <= frame_done & ~parity_ok;
`endif
      if (enable) begin
        shift_reg <= frame_word[FL-1:1];
        case (rx_state_reg)
          RX_IDLE: begin
            if (frame_start) begin
              rx_state_reg <= RX_SHIFT;
              bit_cnt_reg  <= CW'(1);
            end
          end
          RX_SHIFT: begin
            if (frame_start) begin
              bit_cnt_reg <= CW'(1);
            end else if (bit_cnt_reg == LAST_CNT) begin
              rx_state_reg <= RX_IDLE;
              bit_cnt_reg  <= '0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + CW'(1);
            end
          end
          default: rx_state_reg <= RX_IDLE;
        endcase

        if (load) pending_reg <= frame_data;
        else if (hs) pending_reg <= pending_clr;

        done_reg <= final_hs | (load & ~|frame_data);
      end
    end
  end

  assign addr_out = lowest;
  assign done     = done_reg & enable;
  assign overflow = overflow_reg;
  assign busy     = (rx_state_reg == RX_SHIFT) | any | done_reg;

endmodule

// File: tb/tb_sparse_bitstream_decoder.sv
// Directed bench for sparse_bitstream_decoder (SIZE=8); honours SPARSE_DEC_PARITY_EN.
module tb_sparse_bitstream_decoder;

`ifdef SPARSE_DEC_PARITY_EN
  localparam int FL = 9;
`else
  localparam int FL = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic       frame_start = 1'b0;
  logic       bitstream_in = 1'b0;
  logic       addr_ready = 1'b0;
  logic [2:0] addr_out;
  logic       addr_valid, done, overflow, busy;
`ifdef SPARSE_DEC_PARITY_EN
  logic       parity_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sparse_bitstream_decoder #(.SIZE(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .frame_start (frame_start),
    .bitstream_in(bitstream_in),
    .addr_out    (addr_out),
    .addr_valid  (addr_valid),
    .addr_ready  (addr_ready),
    .done        (done),
    .overflow    (overflow),
    .busy        (busy)
`ifdef SPARSE_DEC_PARITY_EN
    ,
    .parity_err  (parity_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      frame;
    int              n;
    logic [7:0][2:0] addrs;  // addrs[0] is replayed first
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs just after the edge, settle, then the caller samples.
  task automatic cyc(input logic fs, input logic b, input logic rdy, input logic en);
    @(posedge clk);
    #1;
    frame_start  = fs;
    bitstream_in = b;
    addr_ready   = rdy;
    enable       = en;
    #1;
  endtask

  task automatic send_frame(input logic [7:0] f, input logic p, input logic rdy,
                            input logic rdy_last);
    for (int i = 0; i < FL; i++) begin
      cyc(i == 0, (i < 8) ? f[i] : p, (i == FL - 1) ? rdy_last : rdy, 1'b1);
    end
  endtask

  task automatic expect_replay(input string tag, input logic [7:0][2:0] a, input int n);
    for (int j = 0; j < n; j++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      chk({tag, " valid"}, int'(addr_valid), 1);
      chk({tag, " addr"}, int'(addr_out), int'(a[j]));
      chk({tag, " early_done"}, int'(done), 0);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk({tag, " done"}, int'(done), 1);
    chk({tag, " valid_at_done"}, int'(addr_valid), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk({tag, " done_clear"}, int'(done), 0);
    chk({tag, " idle_busy"}, int'(busy), 0);
    $display("replay %s: %0d addresses checked", tag, n);
  endtask

  initial begin
    vecs[0] = '{frame: 8'hA4, n: 3, addrs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd5, 3'd2}};
    vecs[1] = '{frame: 8'h00, n: 0, addrs: '0};
    vecs[2] = '{frame: 8'h01, n: 1, addrs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0}};
    vecs[3] = '{frame: 8'h80, n: 1, addrs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7}};
    vecs[4] = '{frame: 8'hFF, n: 8, addrs: {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0}};
    vecs[5] = '{frame: 8'h18, n: 2, addrs: {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4, 3'd3}};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst addr_valid", int'(addr_valid), 0);
    chk("rst done", int'(done), 0);
    chk("rst overflow", int'(overflow), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst addr_out", int'(addr_out), 0);
    reset = 1'b0;
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("idle ignores bits", int'(busy), 0);

    // Table-driven frames with ready held high
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].frame, ^vecs[v].frame, 1'b1, 1'b1);
      expect_replay($sformatf("vec%0d", v), vecs[v].addrs, vecs[v].n);
    end

    // 8'h81 with ready low for three cycles: address 0 must hold
    send_frame(8'h81, 1'b0, 1'b0, 1'b0);
    for (int j = 0; j < 3; j++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b1);
      chk("stall valid", int'(addr_valid), 1);
      chk("stall addr", int'(addr_out), 0);
    end
    expect_replay("stall", {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd0}, 2);

    // Back-to-back with ready low: second frame dropped
    send_frame(8'h06, 1'b0, 1'b0, 1'b0);
    send_frame(8'h01, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovf pulse", int'(overflow), 1);
    chk("ovf keep addr", int'(addr_out), 1);
    expect_replay("ovf", {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd1}, 2);
    chk("ovf single pulse", int'(overflow), 0);

    // Final handshake aligned with the next frame's last bit
    send_frame(8'h02, 1'b1, 1'b0, 1'b0);
    send_frame(8'h30, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("align done", int'(done), 1);
    chk("align valid", int'(addr_valid), 1);
    chk("align addr", int'(addr_out), 4);
    chk("align no ovf", int'(overflow), 0);
    expect_replay("align", {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5}, 1);

    // frame_start at bit 4 restarts the frame
    for (int i = 0; i < 4; i++) cyc(i == 0, 1'b1, 1'b1, 1'b1);
    chk("abort no valid", int'(addr_valid), 0);
    chk("abort busy", int'(busy), 1);
    send_frame(8'h48, 1'b0, 1'b1, 1'b1);
    expect_replay("abort", {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd3}, 2);

    // enable low freezes the handshake and masks valid
    send_frame(8'h0C, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("en_low valid", int'(addr_valid), 0);
    chk("en_low busy", int'(busy), 1);
    expect_replay("en_low", {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd2}, 2);

    // Reset mid-replay of 8'hFF
    send_frame(8'hFF, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("rstrep addr0", int'(addr_out), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("rstrep addr1", int'(addr_out), 1);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    reset = 1'b0;
    chk("rstrep valid", int'(addr_valid), 0);
    chk("rstrep addr", int'(addr_out), 0);
    chk("rstrep busy", int'(busy), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("rstrep no done", int'(done), 0);
    chk("rstrep still idle", int'(addr_valid), 0);

`ifdef SPARSE_DEC_PARITY_EN
    send_frame(8'h03, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("par_bad err", int'(parity_err), 1);
    chk("par_bad valid", int'(addr_valid), 0);
    chk("par_bad ovf", int'(overflow), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("par_bad err clear", int'(parity_err), 0);
    chk("par_bad no done", int'(done), 0);
    send_frame(8'h03, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("par_ok no err", int'(parity_err), 0);
    chk("par_ok addr0", int'(addr_out), 0);
    chk("par_ok valid", int'(addr_valid), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("par_ok addr1", int'(addr_out), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    chk("par_ok done", int'(done), 1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
